conv2_bias_relu: RTL and testbench
==================================

Name: conv2_bias_relu

Overview:
- Post-accumulation stage for conv2, located downstream of the conv2 bias ROM.
- Accepts one batch of NUM_CH signed conv2 accumulator sums and issues a single ROM read for that batch's biases.
- Per channel: adds the bias, applies ReLU, then round-shifts and saturates to an unsigned activation.
- Presents the packed result on a valid/ready handshake to the pooling / activation buffer.

Parameters:
- NUM_CH, 16, channels per batch (matches the ROM word).
- NUM_BATCH, 1, number of conv2 output batches held in the ROM.
- W_BATCH, 1, width of the batch index / ROM address.
- W_ACC, 34, signed accumulator width per channel.
- W_BIAS, 34, signed bias width per channel (ROM lane width).
- W_OUT, 8, unsigned output activation width.
- SHIFT, 24, requantization right shift (0 = no shift, no rounding).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  accumulator batch valid.
- in_ready  out  1  stage can accept.
- in_acc  in  NUM_CH*W_ACC  packed signed sums, channel 0 in the LSBs.
- in_batch  in  W_BATCH  batch index.
- rom_cena  out  1  ROM enable, active-low, registered.
- rom_aa  out  W_BATCH  ROM address, registered.
- rom_qa  in  NUM_CH*W_BIAS  ROM data, channel 0 in the LSBs, valid one cycle after the enable.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  NUM_CH*W_OUT  packed activations, channel 0 in the LSBs.
- out_sat  out  NUM_CH  per-channel saturation flag.
- out_err  out  1  batch index was out of range.

Behaviour:
- Reset values (rst high at a clk edge):
  - state = IDLE, rom_cena = 1, rom_aa = 0.
  - out_valid = 0, out_data = 0, out_sat = 0, out_err = 0.
  - Internal acc/batch registers cleared.
- States: IDLE -> FETCH -> WAIT -> OUT -> IDLE.
- in_ready = 1 only in IDLE, driven combinationally from state.
- IDLE:
  - On in_valid && in_ready: latch in_acc and in_batch, drive rom_aa <= in_batch and rom_cena <= 0, go to FETCH.
  - Set a registered err bit if in_batch >= NUM_BATCH.
- FETCH: the ROM samples the address at this edge; rom_cena <= 1; go to WAIT.
- WAIT:
  - rom_qa is valid.
  - For each channel c: s = sext(acc[c]) + sext(bias[c]) at max(W_ACC, W_BIAS)+1 bits. No overflow is possible.
  - If err is set, bias[c] is forced to 0.
  - ReLU: r = (s < 0) ? 0 : s.
  - Rounding: if SHIFT > 0, q = (r + 2^(SHIFT-1)) >> SHIFT; otherwise q = r. Round half up.
  - Saturation: if q > 2^W_OUT - 1, out_data[c] = 2^W_OUT - 1 and out_sat[c] = 1; otherwise out_data[c] = q and out_sat[c] = 0.
  - Register all results, out_err <= err, out_valid <= 1, go to OUT.
- OUT:
  - Hold out_data, out_sat and out_err stable while out_valid && !out_ready.
  - On out_ready: out_valid <= 0, go to IDLE.
  - No new input is accepted in the same cycle as the handoff; in_ready rises the following cycle.
- Timing:
  - Latency from accept edge to out_valid is 3 edges.
  - Throughput is one batch per 4 cycles with out_ready tied high.
- rom_cena is low for exactly one cycle per accepted batch. rom_aa holds its value until the next accept.
- in_valid in a non-IDLE state is ignored; upstream must hold it until in_ready.
- rst mid-operation (any state): return to IDLE, apply reset values, and discard any pending ROM read.
- rst has priority over all handshakes in the same cycle.
- Out-of-range batch: the result is still produced with zero bias and out_err = 1, and the ROM read is still issued.

Test Plan:
- Reset, then in_acc all 0, batch 0 (ROM biases ch0=-167012672, ch1=210449312, ch3=491355872):
  - rom_cena low exactly one cycle with rom_aa=0.
  - out_valid 3 edges after accept.
  - ch0=0 (ReLU), ch1=13 (rounds up), ch3=29, out_sat=0.
- in_acc ch3 = 2^32, others 0:
  - ch3 = 255, out_sat[3] = 1, other flags 0.
- in_acc ch0 = 167012672 (cancels bias): ch0 = 0.
- in_acc ch0 = 167012672 + 8388608: ch0 = 1 (exact half rounds up).
- Backpressure: out_ready low for 5 cycles:
  - out_valid and out_data held stable, in_ready stays 0.
  - A second in_valid pulse during that time is not accepted.
  - After out_ready rises, next accept occurs no earlier than the following cycle.
- rst asserted during WAIT:
  - Next cycle state is IDLE, out_valid = 0, rom_cena = 1, in_ready = 1, no output emitted.
  - A new batch afterwards completes normally.
- NUM_BATCH=1, in_batch=1, in_acc all 0: all outputs 0, out_err = 1.

Source files
------------

// File: rtl/conv2_bias_relu.sv
`default_nettype none
// ============================================================================
// Module   : conv2_bias_relu
// Brief    : conv2 post-accumulation stage. Takes one batch of signed channel
//            sums, fetches the batch biases from the bias ROM, then per channel
//            adds bias, applies ReLU, round-shifts and saturates to an
//            unsigned activation, presented on a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module conv2_bias_relu #(
    parameter int NUM_CH    = 16,
    parameter int NUM_BATCH = 1,
    parameter int W_BATCH   = 1,
    parameter int W_ACC     = 34,
    parameter int W_BIAS    = 34,
    parameter int W_OUT     = 8,
    parameter int SHIFT     = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    // accumulator batch input
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_CH*W_ACC-1:0]   in_acc,
    input  logic [W_BATCH-1:0]        in_batch,
    // bias ROM port
    output logic                      rom_cena,
    output logic [W_BATCH-1:0]        rom_aa,
    input  logic [NUM_CH*W_BIAS-1:0]  rom_qa,
    // activation output
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_CH*W_OUT-1:0]   out_data,
    output logic [NUM_CH-1:0]         out_sat,
    output logic                      out_err
);

    // Sum width: one guard bit above the wider operand so bias + acc never wraps.
    localparam int c_w_max = (W_ACC > W_BIAS) ? W_ACC : W_BIAS;
    localparam int c_w_sum = c_w_max + 1;
    // One more bit so adding the rounding constant cannot wrap either.
    localparam int c_w_rnd = c_w_sum + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic [NUM_CH*W_ACC-1:0]    r_acc;
    logic                       r_err;

    logic [NUM_CH*W_OUT-1:0]    w_data;
    logic [NUM_CH-1:0]          w_sat;

    // ------------------------------------------------------------------------
    // Per-channel datapath: bias add, ReLU, round-half-up shift, saturation.
    // Evaluated while the ROM word is valid (WAIT) and captured at WAIT exit.
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic signed [W_ACC-1:0]   w_acc;
        logic signed [W_BIAS-1:0]  w_bias;
        logic signed [c_w_sum-1:0] w_sum;
        logic [c_w_sum-1:0]        w_relu;
        logic [c_w_rnd-1:0]        w_q;

        assign w_acc  = r_acc[c*W_ACC +: W_ACC];
        // An out-of-range batch reads garbage from the ROM, so its bias is zeroed.
        assign w_bias = r_err ? '0 : rom_qa[c*W_BIAS +: W_BIAS];
        assign w_sum  = {{(c_w_sum-W_ACC){w_acc[W_ACC-1]}}, w_acc}
                      + {{(c_w_sum-W_BIAS){w_bias[W_BIAS-1]}}, w_bias};
        assign w_relu = w_sum[c_w_sum-1] ? '0 : w_sum;

        if (SHIFT > 0) begin : g_round
            localparam logic [c_w_rnd-1:0] c_half = c_w_rnd'(1) << (SHIFT - 1);
            assign w_q = ({1'b0, w_relu} + c_half) >> SHIFT;
        end else begin : g_noround
            assign w_q = {1'b0, w_relu};
        end

        if (c_w_rnd > W_OUT) begin : g_sat
            assign w_sat[c] = |w_q[c_w_rnd-1:W_OUT];
            assign w_data[c*W_OUT +: W_OUT] = w_sat[c] ? {W_OUT{1'b1}} : w_q[W_OUT-1:0];
        end else begin : g_nosat
            assign w_sat[c] = 1'b0;
            assign w_data[c*W_OUT +: W_OUT] = W_OUT'(w_q);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and input-side ready.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = S_OUT;
            S_OUT: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Input capture, ROM request, and result registers, sequenced by state.
    // rom_aa doubles as the latched batch index for the rest of the batch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_err     <= 1'b0;
            rom_cena  <= 1'b1;
            rom_aa    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
            out_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_acc    <= in_acc;
                        r_err    <= (32'(in_batch) >= NUM_BATCH);
                        rom_aa   <= in_batch;
                        rom_cena <= 1'b0;
                    end
                end
                S_FETCH: begin
                    rom_cena <= 1'b1;
                end
                S_WAIT: begin
                    out_data  <= w_data;
                    out_sat   <= w_sat;
                    out_err   <= r_err;
                    out_valid <= 1'b1;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    rom_cena <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv2_bias_relu.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv2_bias_relu
// Brief    : Self-checking bench for conv2_bias_relu with a bias ROM model and
//            an arithmetic reference model of the per-channel requantisation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv2_bias_relu;

    localparam int NUM_CH    = 16;
    localparam int NUM_BATCH = 1;
    localparam int W_BATCH   = 1;
    localparam int W_ACC     = 34;
    localparam int W_BIAS    = 34;
    localparam int W_OUT     = 8;
    localparam int SHIFT     = 24;

    logic                      clk;
    logic                      rst;
    logic                      in_valid;
    logic                      in_ready;
    logic [NUM_CH*W_ACC-1:0]   in_acc;
    logic [W_BATCH-1:0]        in_batch;
    logic                      rom_cena;
    logic [W_BATCH-1:0]        rom_aa;
    logic [NUM_CH*W_BIAS-1:0]  rom_qa;
    logic                      out_valid;
    logic                      out_ready;
    logic [NUM_CH*W_OUT-1:0]   out_data;
    logic [NUM_CH-1:0]         out_sat;
    logic                      out_err;

    conv2_bias_relu #(
        .NUM_CH(NUM_CH), .NUM_BATCH(NUM_BATCH), .W_BATCH(W_BATCH), .W_ACC(W_ACC),
        .W_BIAS(W_BIAS), .W_OUT(W_OUT), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc), .in_batch(in_batch),
        .rom_cena(rom_cena), .rom_aa(rom_aa), .rom_qa(rom_qa),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int en_cnt   = 0;

    longint                    bias0 [NUM_CH];
    longint                    m_acc [NUM_CH];
    logic [NUM_CH*W_BIAS-1:0]  rom_w0;
    logic [NUM_CH*W_BIAS-1:0]  rom_wbad;
    logic [NUM_CH*W_ACC-1:0]   acc_vec;
    logic [NUM_CH*W_OUT-1:0]   exp_data;
    logic [NUM_CH-1:0]         exp_sat;

    // results of the last do_batch
    logic [NUM_CH*W_OUT-1:0]   got_data;
    logic [NUM_CH-1:0]         got_sat;
    logic                      got_err;
    logic [W_BATCH-1:0]        aa_at_en;
    logic                      cena_after_accept;
    int                        lat;
    int                        en_delta;

    // Synchronous ROM model: data appears the cycle after an enabled edge.
    always @(posedge clk) begin
        if (!rom_cena) begin
            rom_qa <= (rom_aa == 1'b0) ? rom_w0 : rom_wbad;
            en_cnt <= en_cnt + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pack_acc();
        for (int c = 0; c < NUM_CH; c++) begin
            acc_vec[c*W_ACC +: W_ACC] = m_acc[c][W_ACC-1:0];
        end
    endtask

    // Reference: plain integer arithmetic on the channel value.
    task automatic compute_exp(input bit bad_batch);
        longint s;
        for (int c = 0; c < NUM_CH; c++) begin
            s = m_acc[c] + (bad_batch ? 64'sd0 : bias0[c]);
            if (s < 0) s = 0;
            if (SHIFT > 0) s = (s + (longint'(1) << (SHIFT > 0 ? SHIFT - 1 : 0))) / (longint'(1) << SHIFT);
            if (s > (2**W_OUT) - 1) begin
                exp_data[c*W_OUT +: W_OUT] = {W_OUT{1'b1}};
                exp_sat[c] = 1'b1;
            end else begin
                exp_data[c*W_OUT +: W_OUT] = s[W_OUT-1:0];
                exp_sat[c] = 1'b0;
            end
        end
    endtask

    function automatic longint rand_acc();
        longint v;
        case ($urandom_range(0, 2))
            0: begin
                v = longint'({$urandom, $urandom});
                v = (v <<< 30) >>> 30;
            end
            1: v = longint'($urandom) - 64'sh8000_0000;
            default: v = longint'($urandom_range(0, 32'h2000_0000)) - 64'sh1000_0000;
        endcase
        return v;
    endfunction

    // Drive one batch from IDLE and observe it up to out_valid (bounded).
    task automatic do_batch(input logic [W_BATCH-1:0] b, input bit handoff);
        int en0;
        pack_acc();
        in_acc   = acc_vec;
        in_batch = b;
        in_valid = 1'b1;
        en0      = en_cnt;
        step();
        in_valid = 1'b0;
        cena_after_accept = rom_cena;
        aa_at_en = rom_aa;
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        got_data = out_data;
        got_sat  = out_sat;
        got_err  = out_err;
        if (handoff) step();
        en_delta = en_cnt - en0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_acc = '0; in_batch = '0;
        step(); step(); step();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (rom_cena !== 1'b1) begin n_fail++; $display("FAIL reset_rom_cena got=%b exp=1", rom_cena); end
        n_checks++; if (rom_aa !== '0) begin n_fail++; $display("FAIL reset_rom_aa got=%h exp=0", rom_aa); end
        n_checks++; if ({out_data, out_sat, out_err} !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h/%h/%b exp=0", out_data, out_sat, out_err); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        for (int c = 0; c < NUM_CH; c++) m_acc[c] = 0;
        compute_exp(1'b0);
        do_batch(1'b0, 1'b1);
        n_checks++; if (cena_after_accept !== 1'b0 || aa_at_en !== 1'b0) begin n_fail++; $display("FAIL basic_rom_req got cena=%b aa=%h exp cena=0 aa=0", cena_after_accept, aa_at_en); end
        n_checks++; if (en_delta !== 1) begin n_fail++; $display("FAIL basic_rom_cycles got=%0d exp=1", en_delta); end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL basic_latency got=%0d exp=3", lat); end
        n_checks++; if (got_data[7:0] !== 8'd0 || got_data[15:8] !== 8'd13 || got_data[31:24] !== 8'd29) begin n_fail++; $display("FAIL basic_fixed_ch got ch0=%0d ch1=%0d ch3=%0d exp 0/13/29", got_data[7:0], got_data[15:8], got_data[31:24]); end
        n_checks++; if (got_data !== exp_data || got_sat !== 16'h0 || got_err !== 1'b0) begin n_fail++; $display("FAIL basic_model got=%h/%h/%b exp=%h/0/0", got_data, got_sat, got_err, exp_data); end
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_handoff got ready=%b valid=%b exp 1/0", in_ready, out_valid); end
    endtask

    task automatic test_saturate();
        for (int c = 0; c < NUM_CH; c++) m_acc[c] = 0;
        m_acc[3] = 64'sd4294967296;
        compute_exp(1'b0);
        do_batch(1'b0, 1'b1);
        n_checks++; if (got_data[31:24] !== 8'd255 || got_sat !== 16'h0008) begin n_fail++; $display("FAIL sat_ch3 got data=%0d sat=%h exp 255/0008", got_data[31:24], got_sat); end
        n_checks++; if (got_data !== exp_data || got_sat !== exp_sat) begin n_fail++; $display("FAIL sat_model got=%h/%h exp=%h/%h", got_data, got_sat, exp_data, exp_sat); end
    endtask

    task automatic test_rounding();
        for (int c = 0; c < NUM_CH; c++) m_acc[c] = 0;
        m_acc[0] = 64'sd167012672;
        do_batch(1'b0, 1'b1);
        n_checks++; if (got_data[7:0] !== 8'd0) begin n_fail++; $display("FAIL cancel_ch0 got=%0d exp=0", got_data[7:0]); end
        m_acc[0] = 64'sd167012672 + 64'sd8388608;
        compute_exp(1'b0);
        do_batch(1'b0, 1'b1);
        n_checks++; if (got_data[7:0] !== 8'd1) begin n_fail++; $display("FAIL half_up_ch0 got=%0d exp=1", got_data[7:0]); end
        n_checks++; if (got_data !== exp_data || got_sat !== exp_sat) begin n_fail++; $display("FAIL half_model got=%h/%h exp=%h/%h", got_data, got_sat, exp_data, exp_sat); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            for (int c = 0; c < NUM_CH; c++) m_acc[c] = rand_acc();
            compute_exp(1'b0);
            do_batch(1'b0, 1'b1);
            n_checks++; if (got_data !== exp_data || got_sat !== exp_sat || got_err !== 1'b0 || lat !== 3) begin n_fail++; $display("FAIL random_%0d got=%h/%h/%b lat=%0d exp=%h/%h/0 lat=3", i, got_data, got_sat, got_err, lat, exp_data, exp_sat); end
        end
    endtask

    task automatic test_backpressure();
        logic [NUM_CH*W_OUT-1:0] hold;
        int en0;
        out_ready = 1'b0;
        for (int c = 0; c < NUM_CH; c++) m_acc[c] = rand_acc();
        compute_exp(1'b0);
        do_batch(1'b0, 1'b0);
        hold = got_data;
        en0  = en_cnt;
        n_checks++; if (hold !== exp_data) begin n_fail++; $display("FAIL bp_data got=%h exp=%h", hold, exp_data); end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin in_acc = ~acc_vec; in_valid = 1'b1; end
            if (i == 2) in_valid = 1'b0;
            step();
            n_checks++; if (out_valid !== 1'b1 || out_data !== hold || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_%0d got valid=%b data=%h ready=%b exp 1/%h/0", i, out_valid, out_data, in_ready, hold); end
        end
        n_checks++; if (en_cnt !== en0) begin n_fail++; $display("FAIL bp_no_accept got rom reads=%0d exp=0", en_cnt - en0); end
        // Next batch is offered exactly as out_ready rises.
        for (int c = 0; c < NUM_CH; c++) m_acc[c] = rand_acc();
        compute_exp(1'b0);
        pack_acc();
        in_acc = acc_vec; in_batch = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        step();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || rom_cena !== 1'b1) begin n_fail++; $display("FAIL bp_handoff got valid=%b ready=%b cena=%b exp 0/1/1", out_valid, in_ready, rom_cena); end
        step();
        in_valid = 1'b0;
        n_checks++; if (rom_cena !== 1'b0) begin n_fail++; $display("FAIL bp_late_accept got cena=%b exp=0", rom_cena); end
        step(); step();
        n_checks++; if (out_valid !== 1'b1 || out_data !== exp_data || out_sat !== exp_sat) begin n_fail++; $display("FAIL bp_next_batch got=%b/%h/%h exp=1/%h/%h", out_valid, out_data, out_sat, exp_data, exp_sat); end
        step();
    endtask

    task automatic test_back_to_back();
        int en_cyc [$];
        int nvalid;
        for (int c = 0; c < NUM_CH; c++) m_acc[c] = rand_acc();
        compute_exp(1'b0);
        pack_acc();
        in_acc = acc_vec; in_batch = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        nvalid = 0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            step();
            if (!rom_cena) en_cyc.push_back(cyc);
            if (out_valid) begin
                nvalid++;
                n_checks++; if (out_data !== exp_data || out_sat !== exp_sat) begin n_fail++; $display("FAIL b2b_data_c%0d got=%h/%h exp=%h/%h", cyc, out_data, out_sat, exp_data, exp_sat); end
            end
        end
        in_valid = 1'b0;
        n_checks++; if (en_cyc.size() !== 4 || nvalid !== 4) begin n_fail++; $display("FAIL b2b_count got reads=%0d outs=%0d exp 4/4", en_cyc.size(), nvalid); end
        for (int i = 1; i < en_cyc.size(); i++) begin
            n_checks++; if (en_cyc[i] - en_cyc[i-1] !== 4) begin n_fail++; $display("FAIL b2b_interval_%0d got=%0d exp=4", i, en_cyc[i] - en_cyc[i-1]); end
        end
    endtask

    task automatic test_out_of_range();
        for (int c = 0; c < NUM_CH; c++) m_acc[c] = 0;
        compute_exp(1'b1);
        do_batch(1'b1, 1'b1);
        n_checks++; if (aa_at_en !== 1'b1 || cena_after_accept !== 1'b0 || en_delta !== 1) begin n_fail++; $display("FAIL oor_rom_req got aa=%h cena=%b reads=%0d exp 1/0/1", aa_at_en, cena_after_accept, en_delta); end
        n_checks++; if (got_data !== '0 || got_sat !== '0 || got_err !== 1'b1 || exp_data !== '0) begin n_fail++; $display("FAIL oor_result got=%h/%h/%b exp=0/0/1", got_data, got_sat, got_err); end
    endtask

    task automatic test_reset_mid();
        int bad_out;
        for (int c = 0; c < NUM_CH; c++) m_acc[c] = rand_acc();
        pack_acc();
        in_acc = acc_vec; in_batch = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        n_checks++; if (out_valid !== 1'b0 || rom_cena !== 1'b1 || in_ready !== 1'b1 || rom_aa !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl got valid=%b cena=%b ready=%b aa=%h exp 0/1/1/0", out_valid, rom_cena, in_ready, rom_aa); end
        n_checks++; if (out_data !== '0 || out_sat !== '0 || out_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs got=%h/%h/%b exp=0/0/0", out_data, out_sat, out_err); end
        rst = 1'b0;
        bad_out = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid !== 1'b0) bad_out++;
        end
        n_checks++; if (bad_out !== 0) begin n_fail++; $display("FAIL rstmid_no_output got valid cycles=%0d exp=0", bad_out); end
        for (int c = 0; c < NUM_CH; c++) m_acc[c] = rand_acc();
        compute_exp(1'b0);
        do_batch(1'b0, 1'b1);
        n_checks++; if (got_data !== exp_data || got_sat !== exp_sat || got_err !== 1'b0 || lat !== 3) begin n_fail++; $display("FAIL rstmid_after got=%h/%h/%b lat=%0d exp=%h/%h/0 lat=3", got_data, got_sat, got_err, lat, exp_data, exp_sat); end
    endtask

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            bias0[c] = longint'($urandom) - 64'sh8000_0000;
        end
        bias0[0] = -64'sd167012672;
        bias0[1] = 64'sd210449312;
        bias0[3] = 64'sd491355872;
        for (int c = 0; c < NUM_CH; c++) begin
            rom_w0[c*W_BIAS +: W_BIAS]   = bias0[c][W_BIAS-1:0];
            rom_wbad[c*W_BIAS +: W_BIAS] = {2'b00, 2'b01, 30'($urandom)};
        end
        test_reset();
        test_basic();
        test_saturate();
        test_rounding();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
